// File: rtl/kd_point_feeder.sv
// kd_point_feeder: packs coordinate beats into points, buffers them in a FIFO and
// dispatches num_points points per pass to the root cluster PE, one per stable handshake.
module kd_point_feeder #(
   parameter int DIM = 3,
   parameter int DATA_RANGE = 255,
   parameter int DIM_SIZE = $clog2(DATA_RANGE),
   parameter int CENTER_SIZE = DIM * DIM_SIZE,
   parameter int FIFO_DEPTH = 8,
   parameter int COUNT_SIZE = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          coord_valid,
   input  logic [DIM_SIZE-1:0]           coord_in,
   output logic                          coord_ready,
   input  logic                          start,
   input  logic [COUNT_SIZE-1:0]         num_points,
   input  logic                          pe_stable,
   output logic                          receive_point,
   output logic [CENTER_SIZE-1:0]        point_out,
   output logic                          busy,
   output logic                          pass_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = (DIM > 1) ? $clog2(DIM) : 1;
   typedef enum logic [2:0] {IDLE, WAIT_PT, ISSUE, SETTLE, WAIT_STABLE, DONE} state_t;
   state_t state;
   logic [CENTER_SIZE-1:0] mem [FIFO_DEPTH];
   logic [CENTER_SIZE-1:0] asm_word, push_word;
   logic [BW-1:0] beat;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [COUNT_SIZE-1:0] remaining;
   logic ready_en, accept, push, pop;
   // ready_en holds coord_ready low through reset and releases it on the first clock after
   assign coord_ready = ready_en && (fifo_count < (PW+1)'(FIFO_DEPTH));
   assign accept = coord_valid && coord_ready;
   assign push = accept && (beat == BW'(DIM-1));
   assign pop = (state == WAIT_PT) && en && (fifo_count != '0) && pe_stable;
   always_comb begin
      push_word = asm_word;
      push_word[beat*DIM_SIZE +: DIM_SIZE] = coord_in;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_word;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ready_en <= 1'b0;
         beat <= '0;
         asm_word <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            asm_word <= push_word;
            beat <= push ? '0 : beat + 1'b1;
         end
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         remaining <= '0;
         point_out <= '0;
         receive_point <= 1'b0;
         busy <= 1'b0;
         pass_done <= 1'b0;
      end else begin
         receive_point <= 1'b0;
         pass_done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               remaining <= num_points;
               state <= (num_points == '0) ? DONE : WAIT_PT;
               busy <= num_points != '0;
               pass_done <= num_points == '0;
            end
            WAIT_PT: if (pop) begin
               point_out <= mem[rd_ptr];
               receive_point <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: state <= SETTLE;
            SETTLE: state <= WAIT_STABLE;
            WAIT_STABLE: if (pe_stable) begin
               remaining <= remaining - 1'b1;
               state <= (remaining == 1) ? DONE : WAIT_PT;
               busy <= remaining != 1;
               pass_done <= remaining == 1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_kd_point_feeder.sv
// tb_kd_point_feeder: directed scenario tests for kd_point_feeder.
module tb_kd_point_feeder;
   logic clk = 0, rst = 0, en = 0, coord_valid = 0, start = 0, pe_stable = 0;
   logic [7:0] coord_in = 0;
   logic [15:0] num_points = 0;
   logic coord_ready, receive_point, busy, pass_done;
   logic [23:0] point_out;
   logic [3:0] fifo_count;
   int total = 0, bad = 0, strobes = 0, dones = 0;
   logic [23:0] pts[$];

   always #5 clk = ~clk;

   kd_point_feeder dut (
      .clk(clk), .rst(rst), .en(en), .coord_valid(coord_valid), .coord_in(coord_in),
      .coord_ready(coord_ready), .start(start), .num_points(num_points), .pe_stable(pe_stable),
      .receive_point(receive_point), .point_out(point_out), .busy(busy), .pass_done(pass_done),
      .fifo_count(fifo_count)
   );

   // posedge sampling sees the values held during the cycle that just ended
   always @(posedge clk) begin
      if (receive_point) begin strobes++; pts.push_back(point_out); end
      if (pass_done) dones++;
   end

   function automatic logic [23:0] pt(input int p);
      return {8'(p*16+3), 8'(p*16+2), 8'(p*16+1)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 0; en = 0; coord_valid = 0; start = 0; pe_stable = 0; num_points = 0;
      tick(2); rst = 1; tick(2);
   endtask

   task automatic send_beat(input logic [7:0] v);
      int n = 0;
      coord_valid = 1; coord_in = v;
      while (!coord_ready && n < 200) begin tick(1); n++; end
      total++; if (!coord_ready) begin bad++; $display("FAIL beat_timeout got=%0d want=1", coord_ready); end
      tick(1);
      coord_valid = 0;
   endtask

   task automatic send_point(input int p);
      for (int k = 0; k < 3; k++) send_beat(8'(p*16+k+1));
   endtask

   task automatic start_pass(input int n);
      start = 1; num_points = 16'(n); tick(1); start = 0;
   endtask

   task automatic wait_rp(input int lim);
      int n = 0;
      while (!receive_point && n < lim) begin tick(1); n++; end
      total++; if (!receive_point) begin bad++; $display("FAIL strobe_timeout got=0 want=1"); end
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!pass_done && n < lim) begin tick(1); n++; end
      total++; if (!pass_done) begin bad++; $display("FAIL done_timeout got=0 want=1"); end
   endtask

   task automatic test_reset();
      tick(2);
      total++; if (busy !== 0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (receive_point !== 0) begin bad++; $display("FAIL rst_rp got=%b want=0", receive_point); end
      total++; if (pass_done !== 0) begin bad++; $display("FAIL rst_done got=%b want=0", pass_done); end
      total++; if (point_out !== 0) begin bad++; $display("FAIL rst_point got=%h want=0", point_out); end
      total++; if (fifo_count !== 0) begin bad++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
      total++; if (coord_ready !== 0) begin bad++; $display("FAIL rst_ready got=%b want=0", coord_ready); end
      rst = 1; tick(1);
      total++; if (coord_ready !== 1) begin bad++; $display("FAIL rst_ready_rise got=%b want=1", coord_ready); end
   endtask

   task automatic test_pack();
      int s0, d0;
      en = 1; pe_stable = 1;
      send_beat(8'h11); send_beat(8'h22); send_beat(8'h33);
      total++; if (fifo_count !== 1) begin bad++; $display("FAIL pack_count got=%0d want=1", fifo_count); end
      s0 = strobes; d0 = dones;
      start_pass(1);
      total++; if (busy !== 1) begin bad++; $display("FAIL pack_busy got=%b want=1", busy); end
      tick(1);
      total++; if (receive_point !== 1) begin bad++; $display("FAIL pack_rp got=%b want=1", receive_point); end
      total++; if (point_out !== 24'h332211) begin bad++; $display("FAIL pack_point got=%h want=332211", point_out); end
      tick(1);
      total++; if (receive_point !== 0) begin bad++; $display("FAIL pack_rp_once got=%b want=0", receive_point); end
      tick(2);
      total++; if (pass_done !== 1) begin bad++; $display("FAIL pack_done got=%b want=1", pass_done); end
      total++; if (busy !== 0) begin bad++; $display("FAIL pack_busy_end got=%b want=0", busy); end
      tick(1);
      total++; if (pass_done !== 0) begin bad++; $display("FAIL pack_done_pulse got=%b want=0", pass_done); end
      total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL pack_strobes got=%0d want=1", strobes - s0); end
      total++; if (dones - d0 !== 1) begin bad++; $display("FAIL pack_dones got=%0d want=1", dones - d0); end
      total++; if (point_out !== 24'h332211) begin bad++; $display("FAIL pack_hold got=%h want=332211", point_out); end
   endtask

   task automatic test_full();
      int b;
      do_reset(); en = 1; pe_stable = 1;
      for (int p = 0; p < 8; p++) send_point(p);
      total++; if (fifo_count !== 8) begin bad++; $display("FAIL full_count got=%0d want=8", fifo_count); end
      total++; if (coord_ready !== 0) begin bad++; $display("FAIL full_ready got=%b want=0", coord_ready); end
      coord_valid = 1; coord_in = 8'h81; tick(3);
      total++; if (fifo_count !== 8) begin bad++; $display("FAIL full_stall got=%0d want=8", fifo_count); end
      start_pass(1); tick(1);
      total++; if (receive_point !== 1) begin bad++; $display("FAIL full_rp got=%b want=1", receive_point); end
      total++; if (point_out !== pt(0)) begin bad++; $display("FAIL full_point got=%h want=%h", point_out, pt(0)); end
      total++; if (coord_ready !== 1) begin bad++; $display("FAIL full_ready_back got=%b want=1", coord_ready); end
      tick(1); coord_in = 8'h82; tick(1); coord_in = 8'h83; tick(1); coord_valid = 0;
      total++; if (fifo_count !== 8) begin bad++; $display("FAIL full_ninth got=%0d want=8", fifo_count); end
      tick(2);
      b = pts.size();
      start_pass(8); wait_done(200); tick(1);
      total++; if (pts.size() - b !== 8) begin bad++; $display("FAIL full_drain got=%0d want=8", pts.size() - b); end
      for (int i = 0; i < 8 && b + i < pts.size(); i++) begin
         total++; if (pts[b+i] !== pt(i+1)) begin bad++; $display("FAIL full_order%0d got=%h want=%h", i, pts[b+i], pt(i+1)); end
      end
      total++; if (fifo_count !== 0) begin bad++; $display("FAIL full_empty got=%0d want=0", fifo_count); end
   endtask

   task automatic test_backpressure();
      int b, d0, h;
      do_reset(); en = 1; pe_stable = 1;
      send_point(10); send_point(11); send_point(12);
      b = pts.size(); d0 = dones;
      start_pass(3);
      for (int i = 0; i < 3; i++) begin
         wait_rp(20);
         pe_stable = 0; h = 0;
         repeat (10) begin tick(1); if (receive_point) h++; end
         total++; if (h !== 0) begin bad++; $display("FAIL bp_hold%0d got=%0d want=0", i, h); end
         pe_stable = 1;
      end
      wait_done(20); tick(1);
      total++; if (pts.size() - b !== 3) begin bad++; $display("FAIL bp_strobes got=%0d want=3", pts.size() - b); end
      for (int i = 0; i < 3 && b + i < pts.size(); i++) begin
         total++; if (pts[b+i] !== pt(10+i)) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, pts[b+i], pt(10+i)); end
      end
      total++; if (dones - d0 !== 1) begin bad++; $display("FAIL bp_dones got=%0d want=1", dones - d0); end
   endtask

   task automatic test_enable();
      int s0;
      do_reset(); pe_stable = 1; en = 0;
      send_point(2);
      s0 = strobes;
      start_pass(1); tick(5);
      total++; if (busy !== 1) begin bad++; $display("FAIL en_busy got=%b want=1", busy); end
      total++; if (strobes !== s0) begin bad++; $display("FAIL en_blocked got=%0d want=%0d", strobes, s0); end
      en = 1; tick(1);
      total++; if (receive_point !== 1) begin bad++; $display("FAIL en_rp got=%b want=1", receive_point); end
      total++; if (point_out !== pt(2)) begin bad++; $display("FAIL en_point got=%h want=%h", point_out, pt(2)); end
      wait_done(10); tick(1);
   endtask

   task automatic test_zero_ignored();
      int s0, d0, b;
      do_reset(); en = 1; pe_stable = 1;
      s0 = strobes; d0 = dones;
      start_pass(0);
      total++; if (pass_done !== 1) begin bad++; $display("FAIL zero_done got=%b want=1", pass_done); end
      total++; if (busy !== 0) begin bad++; $display("FAIL zero_busy got=%b want=0", busy); end
      tick(1);
      total++; if (pass_done !== 0) begin bad++; $display("FAIL zero_pulse got=%b want=0", pass_done); end
      total++; if (strobes !== s0) begin bad++; $display("FAIL zero_strobe got=%0d want=%0d", strobes, s0); end
      send_point(1); send_point(2); send_point(3);
      b = pts.size();
      start_pass(2); wait_rp(10);
      start = 1; num_points = 5; tick(1); start = 0;
      wait_done(30);
      start = 1; num_points = 1; tick(1); start = 0;
      tick(6);
      total++; if (busy !== 0) begin bad++; $display("FAIL ign_busy got=%b want=0", busy); end
      total++; if (pts.size() - b !== 2) begin bad++; $display("FAIL ign_strobes got=%0d want=2", pts.size() - b); end
      total++; if (fifo_count !== 1) begin bad++; $display("FAIL ign_count got=%0d want=1", fifo_count); end
      total++; if (dones - d0 !== 2) begin bad++; $display("FAIL ign_dones got=%0d want=2", dones - d0); end
   endtask

   task automatic test_async_reset();
      int d0;
      do_reset(); en = 1; pe_stable = 1;
      send_point(3); send_point(4); send_point(5);
      d0 = dones;
      start_pass(3); wait_rp(10);
      pe_stable = 0; tick(4);
      total++; if (fifo_count !== 2) begin bad++; $display("FAIL ar_count_pre got=%0d want=2", fifo_count); end
      send_beat(8'hEE);
      #2 rst = 0; #1;
      total++; if (busy !== 0) begin bad++; $display("FAIL ar_busy got=%b want=0", busy); end
      total++; if (point_out !== 0) begin bad++; $display("FAIL ar_point got=%h want=0", point_out); end
      total++; if (fifo_count !== 0) begin bad++; $display("FAIL ar_count got=%0d want=0", fifo_count); end
      total++; if (coord_ready !== 0) begin bad++; $display("FAIL ar_ready got=%b want=0", coord_ready); end
      @(negedge clk); tick(2);
      total++; if (dones !== d0) begin bad++; $display("FAIL ar_nodone got=%0d want=%0d", dones, d0); end
      rst = 1; pe_stable = 1; tick(1);
      send_point(6);
      total++; if (fifo_count !== 1) begin bad++; $display("FAIL ar_refill got=%0d want=1", fifo_count); end
      start_pass(1); tick(1);
      total++; if (receive_point !== 1) begin bad++; $display("FAIL ar_rp got=%b want=1", receive_point); end
      total++; if (point_out !== pt(6)) begin bad++; $display("FAIL ar_point_new got=%h want=%h", point_out, pt(6)); end
      wait_done(10); tick(1);
   endtask

   initial begin
      test_reset();
      test_pack();
      test_full();
      test_backpressure();
      test_enable();
      test_zero_ignored();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
